uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have these parameters:
- DEPTH, 16, number of byte entries; power of two, 2..256.
- IRQ_LEVEL, 8, occupancy at or above which irq asserts; 1..DEPTH.

REQ-002 The block SHALL have these ports:
- clk  input  1  single clock for all logic; active edge is posedge.
- reset  input  1  synchronous, active-high reset.
- rx_byte  input  8  byte from the UART receiver.
- rx_strobe  input  1  one-cycle pulse; rx_byte holds a good frame.
- rx_frame_error  input  1  one-cycle pulse; the receiver saw a bad STOP bit.
- pop  input  1  one-cycle pulse from the bus side; consume the head byte.
- clear_flags  input  1  one-cycle pulse; clear the sticky flags.
- irq_enable  input  1  level; gates irq.
- dout  output  8  head byte (first-word-fall-through).
- not_empty  output  1  at least one byte is held.
- full  output  1  count equals DEPTH.
- count  output  log2(DEPTH)+1  bytes held.
- overrun  output  1  sticky; a byte was dropped because the FIFO was full.
- frame_error  output  1  sticky; a framing error was reported.
- irq  output  1  interrupt request to the CPU.

Function
REQ-003 The block SHALL store bytes in a circular buffer of DEPTH entries, with a write pointer and a read pointer of log2(DEPTH) bits each.
REQ-004 The block SHALL keep a count register, so that full and empty are decided from count rather than from pointer equality.
REQ-005 When rx_strobe is high and the FIFO is not full, the block SHALL write rx_byte at the write pointer, increment the write pointer (wrapping DEPTH-1 to 0), and increment count.
REQ-006 When rx_strobe is high, pop is low, and the FIFO is full, the block SHALL drop rx_byte, leave pointers and count unchanged, and set overrun.
REQ-007 When pop is high and count is nonzero, the block SHALL increment the read pointer (with wrap) and decrement count.
REQ-008 When pop is high and count is zero, the block SHALL ignore the pop, with no state change and no flag.
REQ-009 When rx_strobe and pop are both high and the FIFO is full, both operations SHALL occur, count SHALL stay at DEPTH, and overrun SHALL NOT set.
REQ-010 When rx_strobe and pop are both high and the FIFO is empty, the push SHALL occur, the pop SHALL be ignored, and count SHALL become 1.
REQ-011 When rx_strobe and pop are both high at any other occupancy, both operations SHALL occur and count SHALL be unchanged.
REQ-012 dout SHALL be the entry at the read pointer, updated so that:
- a byte pushed into an empty FIFO at edge N appears on dout, with not_empty high, after edge N;
- after a pop at edge N, dout shows the next entry after edge N.
REQ-013 dout SHALL be 8'h00 whenever not_empty is low.
REQ-014 not_empty, full, and count SHALL be registered, or derived combinationally from registered count only.
REQ-015 rx_frame_error high SHALL set frame_error and SHALL NOT write a byte; if rx_strobe is also high in that cycle, rx_byte SHALL still be written per REQ-005/006.
REQ-016 clear_flags high SHALL clear overrun and frame_error, except that a set event in the same cycle wins and that flag ends high.
REQ-017 irq SHALL equal irq_enable AND (count >= IRQ_LEVEL OR overrun OR frame_error), registered one cycle after the state that causes it.
REQ-018 The block SHALL have no latches.
REQ-019 The block SHALL not use bus-side clocking; all logic runs on clk.

Reset
REQ-020 When reset is high at a clk edge, the block SHALL clear both pointers and count, so that not_empty=0, full=0, count=0, dout=8'h00.
REQ-021 When reset is high at a clk edge, the block SHALL set overrun=0, frame_error=0, irq=0.
REQ-022 Reset SHALL take priority over rx_strobe, pop, and clear_flags asserted in the same cycle.
REQ-023 Reset asserted mid-operation SHALL discard all held bytes.
REQ-024 Buffer memory contents need not be cleared by reset.

Verification
REQ-025 The bench SHALL cover these directed scenarios (DEPTH=16, IRQ_LEVEL=8):
- Push 8'h41 into an empty FIFO -> one cycle later not_empty=1, dout=8'h41, count=1; pop -> not_empty=0, dout=8'h00.
- Push 8'h00..8'h0F -> full=1, count=16; push 8'hAA -> overrun=1, count=16; pop all 16 -> bytes 8'h00..8'h0F in order, 8'hAA never appears.
- Fill to 16, then push 8'h55 and pop in the same cycle -> count=16, overrun=0, last byte out is 8'h55.
- Wrap-around: push and pop 40 bytes in interleaved bursts of 5 -> output order equals input order, pointers wrap without loss.
- irq_enable=1, push 7 bytes -> irq=0; push 8th -> irq=1 one cycle later; pop 1 -> irq=0; pulse rx_frame_error -> frame_error=1, irq=1; pulse clear_flags together with rx_frame_error -> frame_error stays 1.
- Push 5 bytes, assert reset together with pop and rx_strobe -> count=0, not_empty=0, overrun=0, dout=8'h00 after the edge.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receiver-side and bus-side signal bundle for uart_rx_fifo
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
);
  logic [7:0]               rx_byte;
  logic                     rx_strobe;
  logic                     rx_frame_error;
  logic                     pop;
  logic                     clear_flags;
  logic                     irq_enable;
  logic [7:0]               dout;
  logic                     not_empty;
  logic                     full;
  logic [$clog2(DEPTH):0]   count;
  logic                     overrun;
  logic                     frame_error;
  logic                     irq;

  modport master (
    output rx_byte, rx_strobe, rx_frame_error, pop, clear_flags, irq_enable,
    input  dout, not_empty, full, count, overrun, frame_error, irq
  );

  modport slave (
    input  rx_byte, rx_strobe, rx_frame_error, pop, clear_flags, irq_enable,
    output dout, not_empty, full, count, overrun, frame_error, irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through receive byte FIFO with sticky error flags and irq
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int IRQ_LEVEL = 8
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_fifo_if.slave  bus
);
  localparam int            AW         = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   IRQ_COUNT  = (AW+1)'(IRQ_LEVEL);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          overrun_q;
  logic          frame_error_q;
  logic          irq_q;
  logic          is_empty;
  logic          is_full;
  logic          do_push;
  logic          do_pop;
  logic          overrun_set;

  // A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
  always_comb begin
    is_empty    = (cnt == '0);
    is_full     = (cnt == FULL_COUNT);
    do_pop      = bus.pop && !is_empty;
    do_push     = bus.rx_strobe && (!is_full || bus.pop);
    overrun_set = bus.rx_strobe && is_full && !bus.pop;
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= bus.rx_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cnt           <= '0;
      overrun_q     <= 1'b0;
      frame_error_q <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // A set event in the same cycle as clear_flags leaves the flag high.
      overrun_q     <= overrun_set || (overrun_q && !bus.clear_flags);
      frame_error_q <= bus.rx_frame_error || (frame_error_q && !bus.clear_flags);
      irq_q         <= bus.irq_enable && ((cnt >= IRQ_COUNT) || overrun_q || frame_error_q);
    end
  end

  assign bus.dout        = is_empty ? 8'h00 : mem[rd_ptr];
  assign bus.not_empty   = !is_empty;
  assign bus.full        = is_full;
  assign bus.count       = cnt;
  assign bus.overrun     = overrun_q;
  assign bus.frame_error = frame_error_q;
  assign bus.irq         = irq_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo with directed and random traffic
module tb_uart_rx_fifo;
  localparam int DEPTH     = 16;
  localparam int IRQ_LEVEL = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  bit   ien   = 1'b0;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .IRQ_LEVEL(IRQ_LEVEL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int occ;
    bit ovr;
    bit fe;
    bit irq;
  } exp_t;

  exp_t       state_q[$];
  logic [7:0] data_q[$];
  int         m_occ = 0;
  bit         m_ovr = 1'b0;
  bit         m_fe  = 1'b0;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one cycle of inputs and records what the FIFO must look like after the next edge.
  task automatic step(input bit s, input logic [7:0] b, input bit fe_in,
                      input bit p, input bit c, input bit r);
    exp_t e;
    bit   dpush;
    bit   dpop;
    @(negedge clk);
    #1;
    reset              = r;
    bus.rx_strobe      = s;
    bus.rx_byte        = b;
    bus.rx_frame_error = fe_in;
    bus.pop            = p;
    bus.clear_flags    = c;
    bus.irq_enable     = ien;
    if (r) begin
      m_occ = 0;
      m_ovr = 1'b0;
      m_fe  = 1'b0;
      data_q.delete();
      e = '{0, 1'b0, 1'b0, 1'b0};
    end else begin
      e.irq = ien && (m_occ >= IRQ_LEVEL || m_ovr || m_fe);
      dpush = s && (m_occ < DEPTH || p);
      dpop  = p && (m_occ > 0);
      m_ovr = (s && m_occ == DEPTH && !p) || (m_ovr && !c);
      m_fe  = fe_in || (m_fe && !c);
      if (dpush) data_q.push_back(b);
      m_occ = m_occ + int'(dpush) - int'(dpop);
      e.occ = m_occ;
      e.ovr = m_ovr;
      e.fe  = m_fe;
    end
    state_q.push_back(e);
  endtask

  task automatic push(input logic [7:0] b);
    step(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop1();
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: a pop of a non-empty FIFO consumes the byte that was on dout before the edge.
  initial begin
    exp_t       e;
    logic [7:0] prev_dout = 8'h00;
    bit         prev_ne   = 1'b0;
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (state_q.size() > 0) begin
        e = state_q.pop_front();
        if (!reset && bus.pop && prev_ne) begin
          if (data_q.size() == 0) begin
            check("pop_underflow", 1, 0);
          end else begin
            want = data_q.pop_front();
            check("pop_data", int'(prev_dout), int'(want));
          end
        end
        check("count", int'(bus.count), e.occ);
        check("not_empty", int'(bus.not_empty), int'(e.occ > 0));
        check("full", int'(bus.full), int'(e.occ == DEPTH));
        check("overrun", int'(bus.overrun), int'(e.ovr));
        check("frame_error", int'(bus.frame_error), int'(e.fe));
        check("irq", int'(bus.irq), int'(e.irq));
        if (e.occ == 0) check("dout_empty", int'(bus.dout), 0);
      end
      prev_dout = bus.dout;
      prev_ne   = bus.not_empty;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rx_strobe      = 1'b0;
    bus.rx_byte        = 8'h00;
    bus.rx_frame_error = 1'b0;
    bus.pop            = 1'b0;
    bus.clear_flags    = 1'b0;
    bus.irq_enable     = 1'b0;

    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();

    push(8'h41);
    idle();
    pop1();
    idle();

    for (int i = 0; i < 16; i++) push(8'(i));
    push(8'hAA);
    for (int i = 0; i < 16; i++) pop1();
    idle();

    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) push(8'($urandom));
    step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) pop1();
    idle();

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 5; i++) push(8'(8'h80 + r * 5 + i));
      for (int i = 0; i < 5; i++) pop1();
    end

    ien = 1'b1;
    for (int i = 0; i < 7; i++) push(8'(8'h10 + i));
    idle();
    push(8'h17);
    idle();
    pop1();
    idle();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();

    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();

    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) ien = bit'($urandom_range(0, 1));
      step(bit'($urandom_range(0, 99) < 55), 8'($urandom),
           bit'($urandom_range(0, 99) < 4),  bit'($urandom_range(0, 99) < 45),
           bit'($urandom_range(0, 99) < 5),  bit'($urandom_range(0, 199) == 0));
    end

    for (int i = 0; i < DEPTH + 2; i++) pop1();
    idle();
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", data_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
